uart_rx_fifo: RTL and testbench
===============================

Name: uart_rx_fifo

Overview:
8N1 UART receiver with a show-ahead receive FIFO. It sits directly downstream of the board-level serial pin and upstream of the chip's command/loader logic. It oversamples the serial line with the system clock and assembles bytes. Completed bytes are presented on a valid/ready interface.

Parameters:
HALF_INTERVAL, 433, clock cycles from start-edge detection to the start-bit mid-point sample.
INTERVAL, 868, clock cycles per bit; the bit counter compares against INTERVAL-1.
DEPTH_LOG, 4, log2 of FIFO depth (default depth 16).

Ports:
clk  input  1  system clock.
reset  input  1  synchronous, active-high reset.
uart_rx  input  1  asynchronous serial line; idle high.
out_data  output  8  byte at the FIFO head; valid only while out_valid=1.
out_valid  output  1  FIFO non-empty.
out_ready  input  1  consumer accepts the head byte when out_valid && out_ready at a rising edge.
err_clear  input  1  one-cycle pulse that clears both sticky error flags.
overrun  output  1  sticky; set when a good byte arrives while the FIFO is full and cannot accept it.
frame_error  output  1  sticky; set when the stop bit is sampled as 0.

Behaviour:
- Reset values:
  - out_valid=0, out_data=0, overrun=0, frame_error=0.
  - FIFO empty; FSM in IDLE; bit counter and shift register 0.
  - Synchronizer flops set to 1.
- Input synchronizer: two flops (rx_s). All decisions use rx_s only. Pin-to-rx_s latency is 2 cycles.
- FSM states: IDLE, START, DATA, STOP, WAIT_IDLE.
  - IDLE: on rx_s=0, go to START and clear cnt.
  - START: cnt increments each cycle. At cnt=HALF_INTERVAL-1, sample rx_s.
    - 0: go to DATA, cnt=0, bit index=0.
    - 1: glitch; return to IDLE, no flag set.
  - DATA: at cnt=INTERVAL-1, sample rx_s into bit[index] (LSB first), then cnt=0 and index+1. After index 7 is sampled, go to STOP.
  - STOP: at cnt=INTERVAL-1, sample rx_s.
    - 1: push the byte to the FIFO; go to IDLE.
    - 0: discard the byte, set frame_error, go to WAIT_IDLE.
  - WAIT_IDLE: stay until rx_s=1, then go to IDLE (prevents a break condition from re-triggering).
- Sampling points, measured from the first cycle rx_s=0 is seen in IDLE (cycle 0):
  - start sample at cycle HALF_INTERVAL;
  - data bit k sampled at HALF_INTERVAL + (k+1)*INTERVAL;
  - stop bit sampled at HALF_INTERVAL + 9*INTERVAL.
  - out_valid rises on the cycle after the stop sample (when the FIFO was empty).
- FIFO:
  - Circular buffer of 2^DEPTH_LOG entries; read/write pointers DEPTH_LOG bits, wrapping naturally; count is DEPTH_LOG+1 bits.
  - Show-ahead: out_data = mem[rd_ptr]; out_valid = (count != 0).
  - Pop: when out_valid && out_ready.
  - Push when not full: always accepted.
  - Push when full:
    - accepted if a pop occurs in the same cycle; count unchanged, no overrun;
    - otherwise the byte is dropped, overrun is set, and FIFO contents are untouched.
  - Push and pop when empty: no pop occurs (out_valid=0); the byte is written; count becomes 1.
  - out_ready while empty is ignored.
- Sticky flags:
  - err_clear clears both flags.
  - A set event in the same cycle as err_clear wins: the flag stays/becomes 1.
- Reset mid-frame: returns to IDLE on the next edge. The partial byte is lost and the FIFO is emptied. The next falling edge after reset starts a fresh frame.
- Back-to-back frames: a start bit immediately after a stop bit is detected. IDLE is entered on the cycle after the stop sample, so up to ~HALF_INTERVAL of stop-bit margin remains.

Test Plan:
- Single byte (HALF_INTERVAL=4, INTERVAL=8, out_ready=0):
  - stimulus: drive 0xA5 as 8N1, 8 cycles/bit;
  - response: out_valid rises 2+4+72+1 cycles after the pin start edge, out_data=0xA5, flags 0;
  - then out_ready=1 for one cycle -> out_valid=0.
- Glitch rejection: pin low for 2 cycles, then high -> no byte, FSM back in IDLE, frame_error=0.
- Framing error:
  - stimulus: send 0x3C with stop bit 0, line held low 20 cycles, then high;
  - response: frame_error=1, FIFO empty.
  - follow-up: a subsequent 0x11 is received correctly. err_clear then gives frame_error=0.
- Overrun and wrap (DEPTH_LOG=2, out_ready=0):
  - stimulus: send 0x01..0x05;
  - response: overrun=1 after the 5th byte; draining yields 0x01,0x02,0x03,0x04.
  - then send 0x06..0x09 -> read 0x06..0x09 in order (pointer wrap).
- Full with simultaneous pop:
  - stimulus: FIFO full (4 entries); assert out_ready exactly on the push cycle of a 5th byte 0x55;
  - response: overrun stays 0, count stays 4, 0x55 is read last.
- Reset mid-frame: assert reset for 1 cycle during data bit 3 of a frame; then send 0x7E -> exactly one byte 0x7E is received, no flags set.

Source files
------------

// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver: two-flop synchronizer, oversampling bit FSM, and a
// show-ahead circular FIFO with sticky overrun / framing-error flags.
module uart_rx_fifo #(
  parameter int HALF_INTERVAL = 433,
  parameter int INTERVAL      = 868,
  parameter int DEPTH_LOG     = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       uart_rx,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  input  logic       err_clear,
  output logic       overrun,
  output logic       frame_error
);

  localparam int CW    = $clog2(INTERVAL + 1);
  localparam int DEPTH = 1 << DEPTH_LOG;
  localparam logic [CW-1:0]      HALF_LAST = CW'(HALF_INTERVAL - 1);
  localparam logic [CW-1:0]      BIT_LAST  = CW'(INTERVAL - 1);
  localparam logic [DEPTH_LOG:0] FULL_CNT  = DEPTH[DEPTH_LOG:0];

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_IDLE} state_t;

  logic                 rx_meta, rx_s;
  state_t               state, state_nx;
  logic [CW-1:0]        cnt, cnt_nx;
  logic [2:0]           idx, idx_nx;
  logic [7:0]           shreg, shreg_nx;
  logic                 push, frm_err;

  logic [7:0]           mem [DEPTH];
  logic [DEPTH_LOG-1:0] wr_ptr, rd_ptr;
  logic [DEPTH_LOG:0]   count;
  logic                 pop, full, accept, drop;

  // Synchronizer idles high so reset never looks like a start edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= uart_rx;
      rx_s    <= rx_meta;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
      idx   <= '0;
      shreg <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      idx   <= idx_nx;
      shreg <= shreg_nx;
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    idx_nx   = idx;
    shreg_nx = shreg;
    push     = 1'b0;
    frm_err  = 1'b0;
    case (state)
      IDLE: if (!rx_s) begin
        state_nx = START;
        cnt_nx   = '0;
      end
      START: if (cnt == HALF_LAST) begin
        cnt_nx   = '0;
        idx_nx   = '0;
        state_nx = rx_s ? IDLE : DATA;
      end else cnt_nx = cnt + CW'(1);
      DATA: if (cnt == BIT_LAST) begin
        // LSB arrives first, so shift in from the top.
        cnt_nx   = '0;
        shreg_nx = {rx_s, shreg[7:1]};
        idx_nx   = idx + 3'd1;
        if (idx == 3'd7) state_nx = STOP;
      end else cnt_nx = cnt + CW'(1);
      STOP: if (cnt == BIT_LAST) begin
        cnt_nx = '0;
        if (rx_s) begin
          push     = 1'b1;
          state_nx = IDLE;
        end else begin
          frm_err  = 1'b1;
          state_nx = WAIT_IDLE;
        end
      end else cnt_nx = cnt + CW'(1);
      WAIT_IDLE: if (rx_s) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // A full FIFO still takes the byte when the head leaves in the same cycle.
  assign out_valid = (count != '0);
  assign out_data  = out_valid ? mem[rd_ptr] : 8'h00;
  assign pop       = out_valid && out_ready;
  assign full      = (count == FULL_CNT);
  assign accept    = push && (!full || pop);
  assign drop      = push && full && !pop;

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (accept) wr_ptr <= wr_ptr + 1'b1;
      if (pop)    rd_ptr <= rd_ptr + 1'b1;
      case ({accept, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (accept) mem[wr_ptr] <= shreg;
  end

  // Set beats clear when both land in one cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      overrun     <= 1'b0;
      frame_error <= 1'b0;
    end else begin
      if (drop)           overrun <= 1'b1;
      else if (err_clear) overrun <= 1'b0;
      if (frm_err)        frame_error <= 1'b1;
      else if (err_clear) frame_error <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Randomized and directed bench for uart_rx_fifo against a queue-based
// model of received bytes and sticky flags.
module tb_uart_rx_fifo;
  localparam int H  = 4;
  localparam int I  = 8;
  localparam int DL = 2;
  localparam int DEPTH = 1 << DL;

  logic       clk = 1'b0;
  logic       reset, uart_rx, out_ready, err_clear;
  logic [7:0] out_data;
  logic       out_valid, overrun, frame_error;

  uart_rx_fifo #(.HALF_INTERVAL(H), .INTERVAL(I), .DEPTH_LOG(DL)) dut (
    .clk(clk), .reset(reset), .uart_rx(uart_rx),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .err_clear(err_clear), .overrun(overrun), .frame_error(frame_error)
  );

  always #5 clk = ~clk;

  int         n_cmp = 0;
  int         n_mis = 0;
  int         lat;
  logic [7:0] q[$];
  logic       m_ovr = 1'b0;
  logic       m_fe  = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    uart_rx = 1'b1;
    repeat (n) tick();
  endtask

  task automatic chk_flags(input string tag);
    chk({tag, "_ovr"}, overrun, m_ovr);
    chk({tag, "_fe"}, frame_error, m_fe);
  endtask

  task automatic clear_errs();
    err_clear = 1'b1;
    tick();
    err_clear = 1'b0;
    m_ovr = 1'b0;
    m_fe  = 1'b0;
  endtask

  task automatic pop_chk(input string tag);
    logic [7:0] exp;
    if (q.size() == 0) return;
    exp = q.pop_front();
    chk({tag, "_valid"}, out_valid, 1);
    chk({tag, "_data"}, out_data, exp);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic drain(input string tag);
    while (q.size() > 0) pop_chk(tag);
    chk({tag, "_empty"}, out_valid, 0);
  endtask

  // One 8N1 frame at I cycles/bit; optional head pop on the push cycle,
  // optional reset at tick abort_at (line released high at the same time).
  task automatic send_frame(input logic [7:0] b, input logic stop,
                            input logic pop_at_stop, input int abort_at);
    int   k;
    logic prev_v;
    lat    = -1;
    prev_v = out_valid;
    for (int t = 0; t < 10 * I; t++) begin
      if (t == abort_at) begin
        reset   = 1'b1;
        uart_rx = 1'b1;
        tick();
        reset = 1'b0;
        q.delete();
        m_ovr = 1'b0;
        m_fe  = 1'b0;
        return;
      end
      k = t / I;
      uart_rx = (k == 0) ? 1'b0 : (k == 9) ? stop : b[k-1];
      if (pop_at_stop && t == 10 * I - 2) begin
        chk("simul_pop_head", out_data, q[0]);
        void'(q.pop_front());
        out_ready = 1'b1;
      end
      tick();
      out_ready = 1'b0;
      if (out_valid && !prev_v && lat < 0) lat = t + 1;
      prev_v = out_valid;
    end
    if (!stop) repeat (20) tick();
    idle(12);
    if (stop) begin
      if (q.size() == DEPTH) m_ovr = 1'b1;
      else q.push_back(b);
    end else m_fe = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; uart_rx = 1'b1; out_ready = 1'b0; err_clear = 1'b0;
    repeat (3) tick();
    reset = 1'b0;
    tick();
    chk("rst_valid", out_valid, 0);
    chk("rst_data", out_data, 0);
    chk_flags("rst");

    // single byte, latency from pin start edge
    send_frame(8'hA5, 1'b1, 1'b0, -1);
    chk("single_lat", lat, 2 + H + 9 * I + 1);
    chk_flags("single");
    pop_chk("single");
    chk("single_empty", out_valid, 0);

    // short low pulse must not produce a byte
    uart_rx = 1'b0;
    repeat (2) tick();
    idle(30);
    chk("glitch_valid", out_valid, 0);
    chk_flags("glitch");
    send_frame(8'h5A, 1'b1, 1'b0, -1);
    drain("post_glitch");

    // framing error, then recovery
    send_frame(8'h3C, 1'b0, 1'b0, -1);
    chk_flags("frame");
    chk("frame_valid", out_valid, 0);
    send_frame(8'h11, 1'b1, 1'b0, -1);
    drain("after_frame");
    clear_errs();
    chk_flags("fe_clear");

    // overrun, then pointer wrap
    for (int i = 1; i <= 5; i++) send_frame(8'(i), 1'b1, 1'b0, -1);
    chk_flags("overrun");
    drain("ovr_drain");
    clear_errs();
    for (int i = 6; i <= 9; i++) send_frame(8'(i), 1'b1, 1'b0, -1);
    chk_flags("wrap");
    drain("wrap_drain");

    // push into full FIFO with simultaneous pop
    for (int i = 0; i < 4; i++) send_frame(8'h21 + 8'(i), 1'b1, 1'b0, -1);
    send_frame(8'h55, 1'b1, 1'b1, -1);
    chk_flags("simul");
    drain("simul_drain");

    // reset during data bit 3 with a byte already queued
    send_frame(8'h33, 1'b1, 1'b0, -1);
    send_frame(8'hC3, 1'b1, 1'b0, I + 3 * I + I / 2);
    idle(30);
    chk("midrst_valid", out_valid, 0);
    chk_flags("midrst");
    send_frame(8'h7E, 1'b1, 1'b0, -1);
    chk_flags("post_rst");
    drain("post_rst");

    // random traffic
    for (int n = 0; n < 40; n++) begin
      int npop;
      send_frame(8'($urandom), ($urandom_range(0, 7) != 0), 1'b0, -1);
      chk_flags("rnd");
      npop = $urandom_range(0, q.size());
      repeat (npop) pop_chk("rnd");
      if ($urandom_range(0, 5) == 0) begin
        clear_errs();
        chk_flags("rnd_clr");
      end
    end
    drain("rnd_drain");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end
endmodule
